fdiv_seq: RTL
=============

// Module: fdiv_seq
// PURPOSE
//  Single-precision float divider y = x1 / x2. Computes one quotient bit per cycle (radix-2 restoring).
//  Uses the same number handling as the combinational multiplier: no rounding (truncate),
//  denormals flushed to zero, NaN not distinguished.
//  Sits beside the multiplier in the FPU and is driven by the core through a valid/ready handshake on each side.
// PARAMETERS
//  EBIAS    127  exponent bias added back after the exponent subtraction
//  QBITS    25   quotient bits produced; fixed by format, not meant to be overridden
// PORTS
//  clk        in   1   clock, all state changes on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   x1/x2 valid this cycle
//  in_ready   out  1   block can accept an operation (high only in IDLE)
//  x1         in   32  dividend, IEEE-754 single
//  x2         in   32  divisor, IEEE-754 single
//  out_valid  out  1   y/ovf/dz valid (high only in DONE)
//  out_ready  in   1   consumer takes the result
//  y          out  32  quotient
//  ovf        out  1   finite/finite result overflowed to infinity
//  dz         out  1   finite dividend / zero divisor
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, y=0, ovf=0, dz=0, count=0.
//    Reset in any state (including mid-CALC) abandons the operation with no output.
//  FSM IDLE -> CALC | DONE; CALC -> DONE; DONE -> IDLE.
//  Accept: the operation is taken when in_valid && in_ready at edge T.
//    x1/x2 fields are registered then; later input changes are ignored.
//  Special cases are decided at accept, in priority order; state goes straight to DONE, out_valid high after edge T+1:
//   1. e1==255: y={s,255,0}, ovf=0, dz=0
//   2. e2==255: y={s,0,0}
//   3. e2==0: y={s,255,0}, dz=1
//   4. e1==0: y={s,0,0}
//  Sign s = s1^s2 in every case, including zero and infinity results.
//  Normal path:
//   - Registers at accept: r={1'b0,1'b1,m1} (25b), d={1'b1,m2}, q=0, count=0, state=CALC.
//   - Each CALC cycle: if r>=d then q={q,1}, r=(r-d)<<1; else q={q,0}, r=r<<1. count++.
//   - After the cycle with count==QBITS-1, the result is registered and state goes to DONE.
//     out_valid rises after edge T+QBITS (25 cycles after accept).
//   - Mantissa: ym = q[24] ? q[23:1] : q[22:0]. Truncation only; the remainder is discarded.
//   - Exponent: computed as 10-bit signed, ye = e1 - e2 + EBIAS - (q[24]?0:1).
//       ye >= 255: y={s,255,0}, ovf=1.
//       ye <= 0:   y={s,0,0}, ovf=0 (flush to zero).
//       otherwise: y={s,ye[7:0],ym}.
//  DONE: y/ovf/dz held stable while out_valid && !out_ready; in_ready=0.
//    On out_ready, state goes to IDLE next edge, clearing out_valid, ovf and dz.
//    A new accept is possible one cycle later; there is no same-cycle turnaround.
//  in_ready=0 throughout CALC and DONE; in_valid is ignored there.
// TESTING
//  1. 0x40C00000 / 0x40000000 (6/2), out_ready=1
//       -> y=0x40400000, ovf=0, dz=0; out_valid exactly 25 cycles after accept.
//  2. 0x3F800000 / 0x40400000 (1/3) -> y=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
//  3. 0xBF800000 / 0x40000000 -> y=0xBF000000.
//     0x3F800000 / 0x3F800000 -> y=0x3F800000 (q[24]=1 path).
//  4. 0x3F800000 / 0x00000000 -> y=0x7F800000, dz=1, out_valid 1 cycle after accept.
//     0x7F000000 / 0x3E800000 -> y=0x7F800000, ovf=1.
//     0x00800000 / 0x40000000 -> y=0x00000000.
//  5. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
//       -> y/ovf stable, in_ready=0, in_valid pulses ignored.
//       -> Release out_ready: IDLE next cycle, then back-to-back op accepted.
//  6. Assert rst at count==10 of a CALC
//       -> next cycle IDLE, out_valid=0, y=0.
//       -> A following 6/2 operation gives 0x40400000 with normal latency.

Source files
------------

// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential single-precision divider, y = x1 / x2.
// Produces one quotient bit per clock (radix-2 restoring). Results are
// truncated, denormal inputs/outputs are flushed to zero, and NaN is not
// distinguished from infinity.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   x1/x2 carry an operation this cycle
//   in_ready   divider idle and able to accept
//   x1, x2     dividend / divisor (IEEE-754 single)
//   out_valid  y/ovf/dz hold a result
//   out_ready  consumer takes the result
//   y          quotient
//   ovf        finite/finite result overflowed to infinity
//   dz         finite dividend divided by zero
module fdiv_seq #(
  parameter int EBIAS = 127,
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        dz
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     y_q, y_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;
  logic [24:0]     r_q, r_d;
  logic [23:0]     d_q, d_d;
  logic [24:0]     q_q, q_d;
  logic [7:0]      e1_q, e1_d;
  logic [7:0]      e2_q, e2_d;
  logic            s_q, s_d;

  logic            ge;
  logic [24:0]     q_nxt;

  // Packs the final quotient into {ovf, y}: normalises on q[24], then
  // saturates a too-large exponent to infinity and flushes a too-small one.
  function automatic logic [32:0] pack_result(input logic s, input logic [7:0] e1,
                                              input logic [7:0] e2, input logic [24:0] q);
    logic signed [9:0] ye;
    logic [22:0]       ym;
    ye = $signed({2'b00, e1}) - $signed({2'b00, e2}) + signed'(10'(EBIAS))
         - (q[24] ? 10'sd0 : 10'sd1);
    ym = q[24] ? q[23:1] : q[22:0];
    if (ye >= 10'sd255)    pack_result = {1'b1, s, 8'hFF, 23'd0};
    else if (ye <= 10'sd0) pack_result = {1'b0, s, 31'd0};
    else                   pack_result = {1'b0, s, ye[7:0], ym};
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

  // r >= d decides the next quotient bit; r is one bit wider than d.
  assign ge    = (r_q >= {1'b0, d_q});
  assign q_nxt = {q_q[23:0], ge};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    r_d         = r_q;
    d_d         = d_q;
    q_d         = q_q;
    e1_d        = e1_q;
    e2_d        = e2_q;
    s_d         = s_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = x1[31] ^ x2[31];
          e1_d    = x1[30:23];
          e2_d    = x2[30:23];
          r_d     = {2'b01, x1[22:0]};
          d_d     = {1'b1, x2[22:0]};
          q_d     = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          // Special operands resolve immediately, in priority order.
          if (x1[30:23] == 8'hFF) begin
            y_d     = {x1[31] ^ x2[31], 8'hFF, 23'd0};
            state_d = DONE;
          end else if (x2[30:23] == 8'hFF) begin
            y_d     = {x1[31] ^ x2[31], 31'd0};
            state_d = DONE;
          end else if (x2[30:23] == 8'h00) begin
            y_d     = {x1[31] ^ x2[31], 8'hFF, 23'd0};
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (x1[30:23] == 8'h00) begin
            y_d     = {x1[31] ^ x2[31], 31'd0};
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        q_d     = q_nxt;
        r_d     = ge ? ((r_q - {1'b0, d_q}) << 1) : (r_q << 1);
        count_d = count_q + CW'(1);
        if (count_q == CW'(QBITS - 1)) begin
          {ovf_d, y_d} = pack_result(s_q, e1_q, e2_q, q_nxt);
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        // Entered directly from IDLE on special operands: out_valid rises
        // one cycle into DONE. Leaving requires an actual handshake.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          ovf_d       = 1'b0;
          dz_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    r_q  <= r_d;
    d_q  <= d_d;
    q_q  <= q_d;
    e1_q <= e1_d;
    e2_q <= e2_d;
    s_q  <= s_d;
  end

endmodule
